// File: rtl/svnet_skid_pipe_pkg.sv
// ============================================================================
// Module   : svnet_pkg
// Brief    : Shared types for the svnet skid pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

package svnet_pkg;

    // Bit 0 mirrors M.valid, bit 1 mirrors S.valid.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_BUSY  = 2'b01,
        SKID_FULL  = 2'b11
    } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/svnet_skid_stage.sv
// ============================================================================
// Module   : svnet_skid_stage
// Brief    : One ready/valid skid stage (main + skid register), all outputs from flops.
// Revision : 1.0
// ============================================================================
`default_nettype none

module svnet_skid_stage #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);
    import svnet_pkg::*;

    skid_state_t      r_state;
    skid_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_m_data;
    logic [WIDTH-1:0] r_s_data;
    logic [WIDTH-1:0] w_m_nxt;
    logic [WIDTH-1:0] w_s_nxt;
    logic             r_in_ready;
    logic             w_acc_in;
    logic             w_acc_out;
    logic             w_s_load;

    assign w_acc_in  = in_valid & r_in_ready;
    assign w_acc_out = r_state[0] & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m_data;
        w_s_nxt     = r_s_data;
        w_s_load    = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_acc_in) begin
                    w_state_nxt = SKID_BUSY;
                    w_m_nxt     = in_data;
                end
            end
            SKID_BUSY: begin
                if (w_acc_in && w_acc_out) begin
                    w_m_nxt = in_data;
                end else if (w_acc_in) begin
                    w_state_nxt = SKID_FULL;
                    w_s_nxt     = in_data;
                    w_s_load    = 1'b1;
                end else if (w_acc_out) begin
                    w_state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so only the drain case exists.
                if (w_acc_out) begin
                    w_state_nxt = SKID_BUSY;
                    w_m_nxt     = r_s_data;
                end
            end
            default: w_state_nxt = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= SKID_EMPTY;
            r_m_data   <= INIT;
            r_s_data   <= INIT;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_m_data   <= w_m_nxt;
            r_s_data   <= w_s_nxt;
            r_in_ready <= (w_state_nxt != SKID_FULL);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_state[0];
    assign out_data  = r_m_data;

`ifndef SYNTHESIS
    logic             r_chk_stall;
    logic [WIDTH-1:0] r_chk_data;

    always_ff @(posedge clk) begin
        r_chk_stall <= rst_n & out_valid & ~out_ready;
        r_chk_data  <= out_data;
        if (r_chk_stall) begin
            assert (out_valid && (out_data == r_chk_data))
                else $error("svnet_skid_stage: output changed while stalled");
        end
        if (rst_n) begin
            assert (!(w_s_load && r_state[1]))
                else $error("svnet_skid_stage: skid register overwritten");
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/svnet_skid_pipe.sv
// ============================================================================
// Module   : svnet_skid_pipe
// Brief    : DEPTH cascaded skid stages; DEPTH=0 degenerates to a wire passthrough.
// Revision : 1.0
// ============================================================================
`default_nettype none

module svnet_skid_pipe #(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);
    import svnet_pkg::*;

    generate
        if (DEPTH == 0) begin : g_passthru
            assign out_valid = in_valid;
            assign out_data  = in_data;
            assign in_ready  = out_ready;
        end else begin : g_chain
            logic             w_valid [0:DEPTH];
            logic [WIDTH-1:0] w_data  [0:DEPTH];
            logic             w_ready [0:DEPTH];

            assign w_valid[0]     = in_valid;
            assign w_data[0]      = in_data;
            assign in_ready       = w_ready[0];
            assign out_valid      = w_valid[DEPTH];
            assign out_data       = w_data[DEPTH];
            assign w_ready[DEPTH] = out_ready;

            for (genvar k = 0; k < DEPTH; k++) begin : g_stage
                svnet_skid_stage #(
                    .WIDTH (WIDTH),
                    .INIT  (INIT)
                ) u_stage (
                    .clk       (clk),
                    .rst_n     (rst_n),
                    .in_valid  (w_valid[k]),
                    .in_data   (w_data[k]),
                    .in_ready  (w_ready[k]),
                    .out_valid (w_valid[k+1]),
                    .out_data  (w_data[k+1]),
                    .out_ready (w_ready[k+1])
                );
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_svnet_skid_pipe.sv
// ============================================================================
// Module   : tb_svnet_skid_pipe
// Brief    : Directed DEPTH=1 checks plus randomized DEPTH=3 scoreboard run.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_svnet_skid_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_data;

    svnet_skid_pipe #(.WIDTH(8), .DEPTH(1), .INIT(8'h00)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_ready (a_out_ready)
    );

    svnet_skid_pipe #(.WIDTH(8), .DEPTH(3), .INIT(8'h00)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_ready (b_out_ready)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic [7:0] v_exp;
    logic [7:0] prev_data;
    logic       prev_stall;
    int         got;
    int         cycles;

    initial begin
        rst_n       = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'hAA;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = 8'h00;
        b_out_ready = 1'b0;

        // Reset held with an upstream beat offered
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_out_valid", a_out_valid, 0);
            chk("rst_in_ready",  a_in_ready,  0);
            chk("rst_out_data",  a_out_data,  8'h00);
        end
        chk("rst_b_in_ready", b_in_ready, 0);
        rst_n = 1'b1;
        step();
        chk("rel_in_ready",  a_in_ready,  1);
        chk("rel_out_valid", a_out_valid, 0);
        chk("rel_b_in_ready", b_in_ready, 1);
        a_in_valid = 1'b0;

        // Back-to-back streaming, one cycle latency
        a_out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(i);
            step();
            chk("stream_in_ready",  a_in_ready,  1);
            chk("stream_out_valid", a_out_valid, 1);
            chk("stream_out_data",  a_out_data,  i);
        end
        a_in_valid = 1'b0;
        step();
        chk("stream_drained", a_out_valid, 0);

        // Stall and skid
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h11;
        step();
        chk("skid_m11", a_out_data, 8'h11);
        chk("skid_rdy_after_11", a_in_ready, 1);
        a_in_data = 8'h22;
        step();
        chk("skid_full_ready", a_in_ready, 0);
        chk("skid_hold_m11", a_out_data, 8'h11);
        a_in_data = 8'h33;
        step();
        chk("skid_33_held", a_in_ready, 0);
        chk("skid_still_11", a_out_data, 8'h11);
        a_out_ready = 1'b1;
        step();
        chk("skid_out22_v", a_out_valid, 1);
        chk("skid_out22",   a_out_data, 8'h22);
        chk("skid_ready_back", a_in_ready, 1);
        step();
        a_in_valid = 1'b0;
        chk("skid_out33_v", a_out_valid, 1);
        chk("skid_out33",   a_out_data, 8'h33);
        step();
        chk("skid_drained", a_out_valid, 0);

        // Simultaneous accept and consume in BUSY
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h40;
        step();
        chk("sim_m40", a_out_data, 8'h40);
        a_in_data   = 8'h41;
        a_out_ready = 1'b1;
        step();
        chk("sim_m41",      a_out_data,  8'h41);
        chk("sim_valid",    a_out_valid, 1);
        chk("sim_in_ready", a_in_ready,  1);
        a_in_valid = 1'b0;
        step();
        chk("sim_drained", a_out_valid, 0);

        // Reset with the stage full
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h55;
        step();
        a_in_data = 8'h66;
        step();
        chk("mid_full", a_in_ready, 0);
        a_in_valid = 1'b0;
        rst_n      = 1'b0;
        step();
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_data",  a_out_data,  8'h00);
        chk("mid_rst_ready", a_in_ready,  0);
        rst_n       = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_no_ghost_v", a_out_valid, 0);
            chk("mid_no_ghost_d", a_out_data,  8'h00);
        end

        // Random backpressure on DEPTH=3 against an in-order queue model
        got    = 0;
        cycles = 0;
        while (got < 10000 && cycles < 40000) begin
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_data   = 8'($urandom);
            b_out_ready = 1'($urandom_range(0, 1));
            if (b_out_valid && b_out_ready) begin
                chk("rnd_model_nonempty", (q.size() != 0), 1);
                if (q.size() != 0) begin
                    v_exp = q.pop_front();
                    chk("rnd_data", b_out_data, v_exp);
                    got++;
                end
            end
            if (b_in_valid && b_in_ready) q.push_back(b_in_data);
            chk("rnd_occupancy", (q.size() <= 6), 1);
            prev_stall = b_out_valid & ~b_out_ready;
            prev_data  = b_out_data;
            step();
            cycles++;
            if (prev_stall) begin
                chk("rnd_hold_valid", b_out_valid, 1);
                chk("rnd_hold_data",  b_out_data,  prev_data);
            end
            if (q.size() == 0) chk("rnd_empty_invalid", b_out_valid, 0);
        end
        chk("rnd_beats_done", (got >= 10000), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
